// File: rtl/mac_job_sequencer_pkg.sv
// mac_seq_pkg: FSM states and default widths shared by the MAC job sequencer files.
package mac_seq_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;
    localparam int DEF_BITS  = 16;
    localparam int DEF_B_W   = 8;
    localparam int DEF_ACC_W = 32;
    localparam int DEF_LEN_W = 8;
    localparam int PROD_W    = DEF_BITS + DEF_B_W;
endpackage

// File: rtl/mac_job_sequencer_if.sv
// mac_job_sequencer_if: job control, operand stream and result port of the MAC job sequencer.
interface mac_job_sequencer_if #(
    parameter int BITS  = 16,
    parameter int B_W   = 8,
    parameter int ACC_W = 32,
    parameter int LEN_W = 8
);
    logic [LEN_W-1:0] cfg_len;
    logic             start;
    logic             abort;
    logic             op_valid;
    logic             op_ready;
    logic [BITS-1:0]  op_a;
    logic [B_W-1:0]   op_b;
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res_data;
    logic             res_ovf;
    logic             busy;
    logic             done_pulse;
    logic [LEN_W-1:0] count;

    modport master (
        output cfg_len, start, abort, op_valid, op_a, op_b, res_ready,
        input  op_ready, res_valid, res_data, res_ovf, busy, done_pulse, count
    );
    modport slave (
        input  cfg_len, start, abort, op_valid, op_a, op_b, res_ready,
        output op_ready, res_valid, res_data, res_ovf, busy, done_pulse, count
    );
endinterface

// File: rtl/mac_job_sequencer_pipe.sv
// mac_pipe: two-stage unsigned multiply (stage 1) and wrapping accumulate with sticky carry (stage 2).
module mac_pipe import mac_seq_pkg::*; #(
    parameter int BITS  = DEF_BITS,
    parameter int B_W   = DEF_B_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [BITS-1:0]  a,
    input  logic [B_W-1:0]   b,
    input  logic             clr,
    input  logic             flush,
    output logic [ACC_W-1:0] acc,
    output logic             ovf,
    output logic             busy
);
    localparam int PW = BITS + B_W;

    logic             s1_valid_q, s1_valid_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W:0]   sum;

    always_comb begin
        s1_valid_d = in_valid && !flush;
        prod_d     = in_valid ? PW'(a) * PW'(b) : prod_q;
        sum        = {1'b0, acc_q} + (ACC_W+1)'(prod_q);
        acc_d      = clr ? '0 : s1_valid_q ? sum[ACC_W-1:0] : acc_q;
        ovf_d      = clr ? 1'b0 : ovf_q | (s1_valid_q & sum[ACC_W]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            prod_q     <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            prod_q     <= prod_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
        end
    end

    assign acc  = acc_q;
    assign ovf  = ovf_q;
    assign busy = s1_valid_q;
endmodule

// File: rtl/mac_job_sequencer.sv
// mac_job_sequencer: accepts cfg_len operand pairs per job, accumulates a*b and hands out the sum.
module mac_job_sequencer import mac_seq_pkg::*; #(
    parameter int BITS  = DEF_BITS,
    parameter int B_W   = DEF_B_W,
    parameter int ACC_W = DEF_ACC_W,
    parameter int LEN_W = DEF_LEN_W
) (
    input logic                clk,
    input logic                reset,
    mac_job_sequencer_if.slave bus
);
    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d, count_q, count_d;
    logic             done_q, done_d;
    logic             start_ok, op_ready, op_fire, res_valid, res_fire, flush, pipe_busy;
    logic [ACC_W-1:0] acc;
    logic             ovf;

    always_comb begin
        start_ok  = state_q == IDLE && bus.start && !bus.abort;
        op_ready  = state_q == RUN && count_q < len_q && !bus.abort;
        op_fire   = bus.op_valid && op_ready;
        res_valid = state_q == DONE && !pipe_busy;
        res_fire  = res_valid && bus.res_ready && !bus.abort;
        flush     = bus.abort && state_q != IDLE;
        len_d     = start_ok ? bus.cfg_len : len_q;
        count_d   = start_ok ? '0 : count_q + LEN_W'(op_fire);
        done_d    = res_fire;
        state_d   = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  if (start_ok) state_d = (bus.cfg_len == '0) ? DONE : RUN;
                RUN:   if (op_fire && count_d == len_q) state_d = DRAIN;
                // the final product sits in stage 1 here and lands in acc on this edge
                DRAIN: state_d = DONE;
                DONE:  if (res_fire) state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    mac_pipe #(.BITS(BITS), .B_W(B_W), .ACC_W(ACC_W)) u_pipe (
        .clk      (clk),
        .reset    (reset),
        .in_valid (op_fire),
        .a        (bus.op_a),
        .b        (bus.op_b),
        .clr      (start_ok),
        .flush    (flush),
        .acc      (acc),
        .ovf      (ovf),
        .busy     (pipe_busy)
    );

    assign bus.op_ready   = op_ready;
    assign bus.res_valid  = res_valid;
    assign bus.res_data   = acc;
    assign bus.res_ovf    = ovf;
    assign bus.busy       = state_q != IDLE;
    assign bus.done_pulse = done_q;
    assign bus.count      = count_q;
endmodule

// File: tb/tb_mac_job_sequencer.sv
// tb_mac_job_sequencer: randomized jobs on a 24-bit accumulator instance, checked against a sum-of-products model.
module tb_mac_job_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          total = 0;
    int          bad = 0;
    logic [15:0] pa[16];
    logic [7:0]  pb[16];
    int          lat, hs;
    bit          rdy_seen, tmo;
    logic        dp0, dp1, dp2, bz;

    mac_job_sequencer_if #(.BITS(16), .B_W(8), .ACC_W(24), .LEN_W(8)) bus ();
    mac_job_sequencer #(.BITS(16), .B_W(8), .ACC_W(24), .LEN_W(8)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic longint model_sum(input int n);
        longint s = 0;
        for (int i = 0; i < n; i++) s += longint'(pa[i]) * longint'(pb[i]);
        return s;
    endfunction

    task automatic do_job(input int n, input bit gaps, input int restart_at);
        int k = 0;
        int cyc;
        @(negedge clk);
        bus.start = 1'b1; bus.cfg_len = 8'(n); bus.op_valid = 1'b0;
        rdy_seen = 0; tmo = 1;
        for (cyc = 1; cyc < 300; cyc++) begin
            @(negedge clk);
            bus.start   = (cyc == restart_at);
            bus.cfg_len = (cyc == restart_at) ? 8'd9 : 8'($urandom);
            if (bus.res_valid) begin tmo = 0; break; end
            bus.op_valid = (k < n) && (!gaps || $urandom_range(0, 2) != 0);
            bus.op_a = (k < n) ? pa[k] : 16'($urandom);
            bus.op_b = (k < n) ? pb[k] : 8'($urandom);
            #1;
            if (bus.op_ready) rdy_seen = 1;
            if (bus.op_valid && bus.op_ready) k++;
        end
        bus.op_valid = 1'b0; bus.start = 1'b0;
        lat = cyc; hs = k;
    endtask

    task automatic consume();
        @(negedge clk); dp0 = bus.done_pulse; bus.res_ready = 1'b1;
        @(negedge clk); bus.res_ready = 1'b0; dp1 = bus.done_pulse; bz = bus.busy;
        @(negedge clk); dp2 = bus.done_pulse;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++; if ({bus.op_ready, bus.res_valid, bus.res_ovf, bus.busy, bus.done_pulse} !== 5'b0) begin
            bad++; $display("FAIL reset_flags got=%b want=00000", {bus.op_ready, bus.res_valid, bus.res_ovf, bus.busy, bus.done_pulse});
        end
        total++; if (bus.res_data !== 24'h0) begin bad++; $display("FAIL reset_data got=%0h want=0", bus.res_data); end
        total++; if (bus.count !== 8'h0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.count); end
        reset = 1'b0;
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b want=0", bus.busy); end
    endtask

    task automatic test_basic();
        pa[0] = 2; pb[0] = 3; pa[1] = 4; pb[1] = 5; pa[2] = 10; pb[2] = 10;
        do_job(3, 0, -1);
        total++; if (tmo) begin bad++; $display("FAIL basic_timeout got=none want=res_valid"); end
        total++; if (lat != 5) begin bad++; $display("FAIL basic_latency got=%0d want=5", lat); end
        total++; if (bus.res_data !== 24'd126) begin bad++; $display("FAIL basic_data got=%0d want=126", bus.res_data); end
        total++; if (bus.res_ovf !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%b want=0", bus.res_ovf); end
        total++; if (bus.count !== 8'd3) begin bad++; $display("FAIL basic_count got=%0d want=3", bus.count); end
        consume();
        total++; if ({dp0, dp1, dp2} !== 3'b010) begin bad++; $display("FAIL basic_done_pulse got=%b want=010", {dp0, dp1, dp2}); end
        total++; if (bz !== 1'b0) begin bad++; $display("FAIL basic_idle_after got=%b want=0", bz); end
        total++; if (bus.count !== 8'd3) begin bad++; $display("FAIL basic_count_hold got=%0d want=3", bus.count); end
    endtask

    task automatic test_stalls();
        for (int i = 0; i < 4; i++) begin pa[i] = 1; pb[i] = 1; end
        do_job(4, 1, -1);
        total++; if (tmo) begin bad++; $display("FAIL stall_timeout got=none want=res_valid"); end
        total++; if (bus.res_data !== 24'd4) begin bad++; $display("FAIL stall_data got=%0d want=4", bus.res_data); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++; if ({bus.res_valid, bus.done_pulse} !== 2'b10 || bus.res_data !== 24'd4) begin
                bad++; $display("FAIL stall_hold%0d got=v%b d%b data=%0d want=v1 d0 data=4", i, bus.res_valid, bus.done_pulse, bus.res_data);
            end
        end
        consume();
        total++; if ({dp0, dp1, dp2} !== 3'b010) begin bad++; $display("FAIL stall_done_pulse got=%b want=010", {dp0, dp1, dp2}); end
    endtask

    task automatic test_zero();
        do_job(0, 0, -1);
        total++; if (lat != 1) begin bad++; $display("FAIL zero_latency got=%0d want=1", lat); end
        total++; if (bus.res_data !== 24'd0 || bus.res_ovf !== 1'b0) begin
            bad++; $display("FAIL zero_result got=%0h/%b want=0/0", bus.res_data, bus.res_ovf);
        end
        total++; if (rdy_seen) begin bad++; $display("FAIL zero_op_ready got=1 want=0"); end
        consume();
        total++; if (dp1 !== 1'b1) begin bad++; $display("FAIL zero_done got=%b want=1", dp1); end
    endtask

    task automatic test_overflow();
        pa[0] = 16'hFFFF; pb[0] = 8'hFF; pa[1] = 16'hFFFF; pb[1] = 8'hFF;
        do_job(2, 0, -1);
        total++; if (bus.res_data !== 24'hFDFE02) begin bad++; $display("FAIL ovf_data got=%0h want=fdfe02", bus.res_data); end
        total++; if (bus.res_ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", bus.res_ovf); end
        consume();
        total++; if (bus.res_ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", bus.res_ovf); end
        pa[0] = 3; pb[0] = 4;
        do_job(1, 0, -1);
        total++; if (bus.res_data !== 24'd12 || bus.res_ovf !== 1'b0) begin
            bad++; $display("FAIL ovf_cleared got=%0d/%b want=12/0", bus.res_data, bus.res_ovf);
        end
        consume();
    endtask

    task automatic test_abort();
        int k = 0;
        @(negedge clk); bus.start = 1'b1; bus.cfg_len = 8'd5;
        for (int c = 0; c < 20 && k < 2; c++) begin
            @(negedge clk);
            bus.start = 1'b0; bus.op_valid = 1'b1; bus.op_a = 16'($urandom); bus.op_b = 8'($urandom);
            #1;
            if (bus.op_ready) k++;
        end
        @(negedge clk); bus.abort = 1'b1;
        #1;
        total++; if (bus.op_ready !== 1'b0) begin bad++; $display("FAIL abort_op_ready got=%b want=0", bus.op_ready); end
        @(negedge clk); bus.abort = 1'b0; bus.op_valid = 1'b0;
        total++; if ({bus.busy, bus.res_valid, bus.done_pulse} !== 3'b000) begin
            bad++; $display("FAIL abort_idle got=%b want=000", {bus.busy, bus.res_valid, bus.done_pulse});
        end
        total++; if (bus.count !== 8'd2) begin bad++; $display("FAIL abort_count got=%0d want=2", bus.count); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if ({bus.res_valid, bus.done_pulse} !== 2'b00) begin
                bad++; $display("FAIL abort_quiet%0d got=%b want=00", i, {bus.res_valid, bus.done_pulse});
            end
        end
        pa[0] = 7; pb[0] = 6;
        do_job(1, 0, -1);
        total++; if (bus.res_data !== 24'd42 || lat != 3) begin
            bad++; $display("FAIL abort_next_job got=%0d lat=%0d want=42 lat=3", bus.res_data, lat);
        end
        consume();
    endtask

    task automatic test_ignored_start();
        for (int i = 0; i < 3; i++) begin pa[i] = 16'($urandom); pb[i] = 8'($urandom); end
        do_job(3, 0, 2);
        total++; if (hs != 3 || bus.count !== 8'd3 || lat != 5) begin
            bad++; $display("FAIL restart_ignored got=hs%0d count%0d lat%0d want=hs3 count3 lat5", hs, bus.count, lat);
        end
        total++; if (bus.res_data !== 24'(model_sum(3))) begin
            bad++; $display("FAIL restart_data got=%0h want=%0h", bus.res_data, 24'(model_sum(3)));
        end
        consume();
    endtask

    task automatic test_reset_drain();
        @(negedge clk); bus.start = 1'b1; bus.cfg_len = 8'd2;
        @(negedge clk); bus.start = 1'b0; bus.op_valid = 1'b1; bus.op_a = 16'hFFFF; bus.op_b = 8'hFF;
        @(negedge clk);
        @(negedge clk); bus.op_valid = 1'b0;
        total++; if ({bus.busy, bus.res_valid} !== 2'b10) begin
            bad++; $display("FAIL drain_state got=%b want=10", {bus.busy, bus.res_valid});
        end
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        total++; if ({bus.op_ready, bus.res_valid, bus.res_ovf, bus.busy, bus.done_pulse} !== 5'b0 ||
                     bus.res_data !== 24'h0 || bus.count !== 8'h0) begin
            bad++; $display("FAIL drain_reset got=%b data=%0h count=%0d want=00000 data=0 count=0",
                {bus.op_ready, bus.res_valid, bus.res_ovf, bus.busy, bus.done_pulse}, bus.res_data, bus.count);
        end
        @(negedge clk);
        total++; if ({bus.res_valid, bus.res_data} !== 25'h0) begin
            bad++; $display("FAIL drain_reset_pipe got=%b/%0h want=0/0", bus.res_valid, bus.res_data);
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 25; j++) begin
            int n = $urandom_range(1, 8);
            bit g = 1'($urandom);
            longint s;
            for (int i = 0; i < n; i++) begin pa[i] = 16'($urandom); pb[i] = 8'($urandom); end
            s = model_sum(n);
            do_job(n, g, -1);
            total++; if (tmo || bus.res_data !== 24'(s) || bus.res_ovf !== (s >= 64'h1000000) || bus.count !== 8'(n)) begin
                bad++; $display("FAIL rand%0d got=%0h ovf=%b count=%0d tmo=%0d want=%0h ovf=%b count=%0d",
                    j, bus.res_data, bus.res_ovf, bus.count, tmo, 24'(s), s >= 64'h1000000, n);
            end
            if (!g) begin
                total++; if (lat != n + 2) begin bad++; $display("FAIL rand%0d_latency got=%0d want=%0d", j, lat, n + 2); end
            end
            consume();
            total++; if (dp1 !== 1'b1) begin bad++; $display("FAIL rand%0d_done got=%b want=1", j, dp1); end
        end
    endtask

    initial begin
        bus.cfg_len = '0; bus.start = 1'b0; bus.abort = 1'b0; bus.op_valid = 1'b0;
        bus.op_a = '0; bus.op_b = '0; bus.res_ready = 1'b0;
        test_reset();
        test_basic();
        test_stalls();
        test_zero();
        test_overflow();
        test_abort();
        test_ignored_start();
        test_reset_drain();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
